vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Owns the single-port framebuffer RAM that sits behind the VGA sync generator.
- Display fetch has absolute priority: reads are issued from the live scan position (pixel_x, pixel_y, video_on).
- Spare cycles are shared round-robin between two write requesters, plus an internal clear sequencer.
- Delays hsync/vsync so they stay aligned with the registered pixel output driven to the DAC/pins.

Parameters:
- FB_W, 160, framebuffer width in words
- FB_H, 120, framebuffer height in words
- SCALE_SHIFT, 2, screen-to-framebuffer downscale (log2); 640>>2=160
- AW, 15, RAM address width; FB_W*FB_H must be <= 2**AW
- DW, 8, pixel word width (RGB332)
- CLEAR_COLOR, 0, word written by the clear sequencer

Ports:
- clk_25mhz  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- pixel_x  in  10  scan column from sync generator
- pixel_y  in  10  scan row from sync generator
- video_on  in  1  active-area flag from sync generator
- hsync_in  in  1  from sync generator
- vsync_in  in  1  from sync generator
- w0_valid  in  1  writer 0 request
- w0_addr  in  AW  writer 0 address
- w0_data  in  DW  writer 0 data
- w0_ready  out  1  writer 0 grant (combinational)
- w1_valid  in  1  writer 1 request
- w1_addr  in  AW  writer 1 address
- w1_data  in  DW  writer 1 data
- w1_ready  out  1  writer 1 grant (combinational)
- clear_req  in  1  one-cycle pulse; start a full clear
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse on last clear write
- mem_addr  out  AW  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_wdata  out  DW  RAM write data (combinational)
- mem_rdata  in  DW  RAM read data; synchronous, 1-cycle latency
- pix_rgb  out  DW  registered pixel output
- hsync_out  out  1  hsync_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles

Behaviour:
- Reset values:
  - pix_rgb=0, hsync_out=1, vsync_out=1
  - clear_busy=0, clear_done=0
  - state=IDLE, last_grant=1 (writer 0 wins the first tie)
  - All delay-pipe stages cleared: syncs to 1, video flag to 0.
- Display need:
  - disp_need = video_on.
  - Address = (pixel_y>>SCALE_SHIFT)*FB_W + (pixel_x>>SCALE_SHIFT), truncated to AW.
  - When disp_need: mem_we=0, mem_addr=display address, both w*_ready=0.
- Pixel pipeline:
  - Cycle N: address issued. N+1: mem_rdata valid. N+2: pix_rgb registered.
  - pix_rgb=0 when the video_on delayed 2 cycles is 0.
  - If the N+1 cycle issued no display read, pix_rgb holds the last captured word (only reachable with the optional feature).
- Free slot (disp_need=0), state machine with 2 states:
  - IDLE:
    - clear_req → CLEAR, clear counter=0, clear_busy=1 on the next cycle.
    - Otherwise serve writers. Only one valid: grant it. Both valid: grant !last_grant.
    - Grant = ready high that cycle. Transfer occurs on valid&ready.
    - On transfer: mem_we=1, mem_addr/mem_wdata from the winner, last_grant updated.
    - Transfers with addr >= FB_W*FB_H: accepted (ready=1) but mem_we forced 0.
  - CLEAR:
    - Writers stalled (ready=0).
    - Each free slot writes CLEAR_COLOR at the counter, then counter++.
    - On write of FB_W*FB_H-1: clear_done pulses that cycle, return to IDLE, clear_busy=0 next cycle.
    - clear_req while in CLEAR is ignored.
- Simultaneous clear_req and writer valid in IDLE: clear wins; no writer is granted that cycle.
- No free slot: nothing advances. Writers hold valid; clear counter holds.
- Asynchronous reset mid-clear aborts the clear; counter and state return to reset values. RAM contents are undefined.
- Idle free cycles: mem_we=0, mem_addr=0.

Optional Feature:
- Macro: VGA_FB_GAP_SLOT_EN.
- Defined:
  - disp_need = video_on && (pixel_x[SCALE_SHIFT-1:0]==0); one read per 2**SCALE_SHIFT columns.
  - The other active cycles become free slots; pix_rgb holds between reads.
- Undefined: disp_need = video_on; writes and clears occur only in blanking.

Test Plan:
1. Preload RAM addr 161 = 8'hE3. Drive pixel_x=4, pixel_y=4, video_on=1 → mem_addr=161, mem_we=0; pix_rgb=8'hE3 two cycles later; hsync_out equals hsync_in delayed 2 cycles.
2. w0_valid=w1_valid=1 held for 4 blanking cycles after reset → grants w0,w1,w0,w1; mem_we=1 each cycle; no grant while video_on=1.
3. clear_req in blanking with w0_valid=1 → w0_ready=0 throughout the clear. All 19200 words written CLEAR_COLOR, spread across blanking only; one clear_done pulse; clear_busy=0 next cycle; w0 then granted.
4. Reset asserted with clear counter=500 → clear_busy=0, state IDLE; a new clear_req restarts at address 0.
5. w1 writes addr 19200 in blanking → w1_ready=1, mem_we=0.
6. With VGA_FB_GAP_SLOT_EN, video_on=1, pixel_x=1..3, w0_valid=1 → three writes granted; pix_rgb constant across the block.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer bus bundle: two write requesters plus the single-port RAM port.
// The arbiter is the slave; requesters/RAM model drive the master side.
interface vga_fb_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic          w0_valid;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_data;
  logic          w0_ready;
  logic          w1_valid;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_data;
  logic          w1_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data, mem_rdata,
    output w0_ready, w1_ready, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data, mem_rdata,
    input  w0_ready, w1_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM owner: display reads first, spare slots go to a clear sequencer or two
// round-robin writers. Define VGA_FB_GAP_SLOT_EN to also free the non-fetch active-video cycles.
module vga_fb_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int AW          = 15,
  parameter int DW          = 8,
  parameter int CLEAR_COLOR = 0
) (
  input  logic          clk_25mhz,
  input  logic          reset_n,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          video_on,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [DW-1:0] pix_rgb,
  output logic          hsync_out,
  output logic          vsync_out,
  vga_fb_arbiter_if.slave bus
);

  localparam int            NWORDS    = FB_W * FB_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_CLEAR  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          vid_d1_q, vid_d1_d;
  logic          rd_d1_q, rd_d1_d;
  logic          hs1_q, hs1_d, hs2_q, hs2_d;
  logic          vs1_q, vs1_d, vs2_q, vs2_d;
  logic [DW-1:0] pix_q, pix_d;

  logic          disp_need;
  logic [AW-1:0] disp_addr;
  logic          pick0, pick1;
  logic          w0_in_range, w1_in_range;

`ifdef VGA_FB_GAP_SLOT_EN
  assign disp_need = video_on && (pixel_x[SCALE_SHIFT-1:0] == '0);
`else
  assign disp_need = video_on;
`endif

  // Arithmetic is done at AW bits so the address wraps exactly like the RAM port.
  assign disp_addr = AW'(pixel_y >> SCALE_SHIFT) * AW'(FB_W) + AW'(pixel_x >> SCALE_SHIFT);

  // last_grant_q=1 means writer 1 won last, so writer 0 takes the next tie.
  assign pick0 = bus.w0_valid && (!bus.w1_valid || last_grant_q);
  assign pick1 = bus.w1_valid && (!bus.w0_valid || !last_grant_q);
  assign w0_in_range = 32'(bus.w0_addr) < 32'(NWORDS);
  assign w1_in_range = 32'(bus.w1_addr) < 32'(NWORDS);

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    last_grant_d  = last_grant_q;
    bus.w0_ready  = 1'b0;
    bus.w1_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    clear_done    = 1'b0;
    if (disp_need) begin
      bus.mem_addr = disp_addr;
    end else if (state_q == ST_IDLE) begin
      if (clear_req) begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end else if (pick0) begin
        bus.w0_ready  = 1'b1;
        bus.mem_addr  = bus.w0_addr;
        bus.mem_wdata = bus.w0_data;
        bus.mem_we    = w0_in_range;
        last_grant_d  = 1'b0;
      end else if (pick1) begin
        bus.w1_ready  = 1'b1;
        bus.mem_addr  = bus.w1_addr;
        bus.mem_wdata = bus.w1_data;
        bus.mem_we    = w1_in_range;
        last_grant_d  = 1'b1;
      end
    end else begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = clr_cnt_q;
      bus.mem_wdata = DW'(CLEAR_COLOR);
      if (clr_cnt_q == LAST_ADDR) begin
        clear_done = 1'b1;
        state_d    = ST_IDLE;
        clr_cnt_d  = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
    end
  end

  // Pixel path: address at N, RAM data at N+1, registered pixel at N+2.
  always_comb begin
    vid_d1_d = video_on;
    rd_d1_d  = disp_need;
    hs1_d    = hsync_in;
    hs2_d    = hs1_q;
    vs1_d    = vsync_in;
    vs2_d    = vs1_q;
    pix_d    = pix_q;
    if (!vid_d1_q) begin
      pix_d = '0;
    end else if (rd_d1_q) begin
      pix_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      vid_d1_q     <= 1'b0;
      rd_d1_q      <= 1'b0;
      hs1_q        <= 1'b1;
      hs2_q        <= 1'b1;
      vs1_q        <= 1'b1;
      vs2_q        <= 1'b1;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      vid_d1_q     <= vid_d1_d;
      rd_d1_q      <= rd_d1_d;
      hs1_q        <= hs1_d;
      hs2_q        <= hs2_d;
      vs1_q        <= vs1_d;
      vs2_q        <= vs2_d;
      pix_q        <= pix_d;
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign pix_rgb    = pix_q;
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: vector table, hand sequences and a
// cycle-level reference model fed with random scan/writer stimulus.
module tb_vga_fb_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int NW = 160 * 120;

  logic          clk_25mhz = 1'b0;
  logic          reset_n   = 1'b0;
  logic [9:0]    pixel_x, pixel_y;
  logic          video_on, hsync_in, vsync_in, clear_req;
  logic          clear_busy, clear_done, hsync_out, vsync_out;
  logic [DW-1:0] pix_rgb;
  logic          preload = 1'b0;

  always #5 clk_25mhz = ~clk_25mhz;

  vga_fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vga_fb_arbiter dut (
    .clk_25mhz (clk_25mhz),
    .reset_n   (reset_n),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .pix_rgb   (pix_rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .bus       (bus)
  );

  // Synchronous single-port RAM, 1-cycle read latency, read-before-write.
  logic [DW-1:0] ram [0:32767] = '{default: 8'h00};
  always @(posedge clk_25mhz) begin
    if (preload) ram[161] <= 8'hE3;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model state, expressed as plain per-cycle rules.
  typedef struct { int vid; int disp; int val; } hist_t;
  int    mram [NW];
  int    m_clr, m_ptr, m_last, m_pix, m_hs1, m_hs2, m_vs1, m_vs2;
  hist_t prev_h;

  task automatic model_reset();
    m_clr = 0; m_ptr = 0; m_last = 1; m_pix = 0;
    m_hs1 = 1; m_hs2 = 1; m_vs1 = 1; m_vs2 = 1;
    prev_h = '{0, 0, 0};
  endtask

  task automatic tick();
    int daddr, disp, e_we, e_addr, e_wd, e_r0, e_r1, e_done, win, a0, a1;
    hist_t cur;
    @(negedge clk_25mhz);
    if (!reset_n) begin
      chk("rst_pix", int'(pix_rgb), 0);
      chk("rst_hsync", int'(hsync_out), 1);
      chk("rst_vsync", int'(vsync_out), 1);
      chk("rst_busy", int'(clear_busy), 0);
      chk("rst_done", int'(clear_done), 0);
      model_reset();
    end else begin
      disp = int'(video_on);
`ifdef VGA_FB_GAP_SLOT_EN
      disp = (video_on && (int'(pixel_x) % 4 == 0)) ? 1 : 0;
`endif
      daddr = (int'(pixel_y) / 4) * 160 + int'(pixel_x) / 4;
      a0 = int'(bus.w0_addr);
      a1 = int'(bus.w1_addr);
      e_we = 0; e_addr = 0; e_wd = 0; e_r0 = 0; e_r1 = 0; e_done = 0; win = -1;
      if (disp != 0) begin
        e_addr = daddr;
      end else if (m_clr != 0) begin
        e_we = 1; e_addr = m_ptr; e_wd = 0; e_done = (m_ptr == NW - 1) ? 1 : 0;
      end else if (!clear_req) begin
        if (bus.w0_valid && bus.w1_valid) win = (m_last == 0) ? 1 : 0;
        else if (bus.w0_valid) win = 0;
        else if (bus.w1_valid) win = 1;
        if (win == 0) begin
          e_r0 = 1; e_addr = a0; e_wd = int'(bus.w0_data); e_we = (a0 < NW) ? 1 : 0;
        end else if (win == 1) begin
          e_r1 = 1; e_addr = a1; e_wd = int'(bus.w1_data); e_we = (a1 < NW) ? 1 : 0;
        end
      end
      chk("w0_ready", int'(bus.w0_ready), e_r0);
      chk("w1_ready", int'(bus.w1_ready), e_r1);
      chk("mem_we", int'(bus.mem_we), e_we);
      chk("mem_addr", int'(bus.mem_addr), e_addr);
      if (e_we != 0) chk("mem_wdata", int'(bus.mem_wdata), e_wd);
      chk("clear_done", int'(clear_done), e_done);
      chk("clear_busy", int'(clear_busy), m_clr);
      chk("pix_rgb", int'(pix_rgb), m_pix);
      chk("hsync_out", int'(hsync_out), m_hs2);
      chk("vsync_out", int'(vsync_out), m_vs2);
      cur.vid = int'(video_on); cur.disp = disp; cur.val = mram[daddr];
      m_pix = (prev_h.vid == 0) ? 0 : ((prev_h.disp != 0) ? prev_h.val : m_pix);
      prev_h = cur;
      if (e_we != 0) mram[e_addr] = e_wd;
      if (disp == 0) begin
        if (m_clr != 0) begin
          if (e_done != 0) begin m_clr = 0; m_ptr = 0; end
          else m_ptr++;
        end else if (clear_req) begin
          m_clr = 1; m_ptr = 0;
        end else if (win >= 0) begin
          m_last = win;
        end
      end
      m_hs2 = m_hs1; m_hs1 = int'(hsync_in);
      m_vs2 = m_vs1; m_vs1 = int'(vsync_in);
    end
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic set_w(input int v0, input int ad0, input int d0,
                       input int v1, input int ad1, input int d1);
    bus.w0_valid = v0[0]; bus.w0_addr = AW'(ad0); bus.w0_data = DW'(d0);
    bus.w1_valid = v1[0]; bus.w1_addr = AW'(ad1); bus.w1_data = DW'(d1);
  endtask

  typedef struct {
    int vid, px, py, w0v, a0, d0, w1v, a1, d1;
    int r0, r1, we, addr, wd;
  } vec_t;
  vec_t tv [9];

  initial begin
    int dones, seen, nz, p_ref;
    pixel_x = '0; pixel_y = '0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    clear_req = 1'b0;
    set_w(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NW; i++) mram[i] = 0;
    mram[161] = 'hE3;
    model_reset();
    tv[0] = '{0, 0, 0, 1, 10, 'hA1, 1, 20, 'hB2,    1, 0, 1, 10, 'hA1};
    tv[1] = '{0, 0, 0, 1, 10, 'hA1, 1, 20, 'hB2,    0, 1, 1, 20, 'hB2};
    tv[2] = '{1, 8, 8, 1, 10, 'hA1, 1, 20, 'hB2,    0, 0, 0, 322, 0};
    tv[3] = '{0, 0, 0, 1, 10, 'hA1, 1, 20, 'hB2,    1, 0, 1, 10, 'hA1};
    tv[4] = '{0, 0, 0, 1, 10, 'hA1, 1, 20, 'hB2,    0, 1, 1, 20, 'hB2};
    tv[5] = '{0, 0, 0, 0, 0, 0, 1, 19200, 'hC3,     0, 1, 0, 19200, 'hC3};
    tv[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0};
    tv[7] = '{0, 0, 0, 1, 5, 'hD4, 0, 0, 0,         1, 0, 1, 5, 'hD4};
    tv[8] = '{0, 0, 0, 1, 30, 'hE5, 1, 40, 'hF6,    0, 1, 1, 40, 'hF6};

    // Reset: registered outputs at reset values, RAM word 161 preloaded.
    preload = 1'b1;
    repeat (3) tick();
    preload = 1'b0;
    reset_n = 1'b1;

    // Vector table: round-robin, display priority, out-of-range accept.
    for (int i = 0; i < 9; i++) begin
      video_on = tv[i].vid[0]; pixel_x = 10'(tv[i].px); pixel_y = 10'(tv[i].py);
      set_w(tv[i].w0v, tv[i].a0, tv[i].d0, tv[i].w1v, tv[i].a1, tv[i].d1);
      #3;
      chk($sformatf("vec%0d_w0_ready", i), int'(bus.w0_ready), tv[i].r0);
      chk($sformatf("vec%0d_w1_ready", i), int'(bus.w1_ready), tv[i].r1);
      chk($sformatf("vec%0d_mem_we", i), int'(bus.mem_we), tv[i].we);
      chk($sformatf("vec%0d_mem_addr", i), int'(bus.mem_addr), tv[i].addr);
      if (tv[i].we != 0) chk($sformatf("vec%0d_mem_wdata", i), int'(bus.mem_wdata), tv[i].wd);
      tick();
    end
    set_w(0, 0, 0, 0, 0, 0);
    video_on = 1'b0;

    // Display fetch of preloaded word, 2-cycle pixel and sync latency.
    pixel_x = 10'd4; pixel_y = 10'd4; video_on = 1'b1; hsync_in = 1'b0;
    #3;
    chk("fetch_addr", int'(bus.mem_addr), 161);
    chk("fetch_we", int'(bus.mem_we), 0);
    tick();
    video_on = 1'b0; hsync_in = 1'b1;
    #3;
    chk("hsync_n1", int'(hsync_out), 1);
    tick();
    #3;
    chk("fetch_pix", int'(pix_rgb), 'hE3);
    chk("hsync_n2", int'(hsync_out), 0);
    tick();

`ifdef VGA_FB_GAP_SLOT_EN
    // Gap slots: columns 1..3 of each 4-column block are free for writers.
    video_on = 1'b1; pixel_y = 10'd0;
    p_ref = 0;
    for (int x = 0; x < 8; x++) begin
      pixel_x = 10'(x);
      set_w(1, 300 + x, x, 0, 0, 0);
      #3;
      chk($sformatf("gap_w0_ready_x%0d", x), int'(bus.w0_ready), (x % 4 != 0) ? 1 : 0);
      if (x == 2) p_ref = int'(pix_rgb);
      if (x > 2 && x < 6) chk($sformatf("gap_pix_hold_x%0d", x), int'(pix_rgb), p_ref);
      tick();
    end
    set_w(0, 0, 0, 0, 0, 0);
    video_on = 1'b0;
`endif

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      video_on = ($urandom_range(0, 1) == 0);
      pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 479));
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      set_w(int'($urandom_range(0, 1)), int'($urandom_range(0, 19230)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 19230)), int'($urandom_range(0, 255)));
      tick();
    end

    // Full clear, interrupted by random active video; writer 0 waits throughout.
    video_on = 1'b0; clear_req = 1'b1;
    set_w(1, 7, 'h55, 0, 0, 0);
    #3;
    chk("clr_vs_writer_ready", int'(bus.w0_ready), 0);
    chk("clr_vs_writer_we", int'(bus.mem_we), 0);
    tick();
    clear_req = 1'b0;
    dones = 0; seen = 0;
    for (int c = 0; c < 40000 && seen == 0; c++) begin
      video_on = ($urandom_range(0, 3) == 0);
      pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 479));
      clear_req = ($urandom_range(0, 99) == 0);
      #3;
      if (clear_done) begin dones++; seen = 1; end
      tick();
    end
    clear_req = 1'b0;
    chk("clear_finished", seen, 1);
    nz = 0;
    for (int i = 0; i < NW; i++) if (ram[i] != 8'h00) nz++;
    chk("ram_words_not_cleared", nz, 0);
    video_on = 1'b0;
    #3;
    chk("busy_after_done", int'(clear_busy), 0);
    chk("w0_after_clear", int'(bus.w0_ready), 1);
    tick();
    set_w(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      #3;
      if (clear_done) dones++;
      tick();
    end
    chk("clear_done_pulses", dones, 1);

    // Reset part-way through a clear (counter at 500), then restart from 0.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (500) tick();
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(clear_busy), 0);
    tick();
    reset_n = 1'b1;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    #3;
    chk("restart_addr", int'(bus.mem_addr), 0);
    chk("restart_we", int'(bus.mem_we), 1);
    tick();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
